// File: rtl/rr_arbiter16.sv
// rr_arbiter16: round-robin arbiter for 16 requesters with a bounded hold time.
// The winner is registered as both an index and a one-hot grant. Ownership ends
// on done, when the owner drops its request, or when the hold limit is reached.
module rr_arbiter16 #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] grant,
    output logic [3:0]  grant_idx,
    output logic        busy,
    output logic        timeout
);

    // Counter wide enough to reach MAX_HOLD-1; at least one bit for MAX_HOLD=2.
    localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [3:0]      r_ptr;
    logic [HC_W-1:0] r_hold_cnt;
    logic [15:0]     r_grant;
    logic [3:0]      r_grant_idx;
    logic            r_busy;
    logic            r_timeout;

    // Requests rotated so that bit 0 is the requester at the priority pointer.
    logic [15:0] w_rot;
    logic [3:0]  w_rot_first;
    logic [3:0]  w_winner;
    logic        w_owner_req;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rot
            assign w_rot[gi] = req[4'(gi) + r_ptr];
        end
    endgenerate

    // Lowest set bit of the rotated vector is the first requester from ptr onward.
    always_comb begin
        w_rot_first = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_rot_first = 4'(i);
            end
        end
    end

    // Undo the rotation; the 4-bit add wraps past requester 15.
    assign w_winner    = w_rot_first + r_ptr;
    assign w_owner_req = req[r_grant_idx];

    // Arbitration FSM: grant from IDLE, release from BUSY, all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 4'd0;
            r_hold_cnt  <= '0;
            r_grant     <= 16'h0000;
            r_grant_idx <= 4'd0;
            r_busy      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timeout <= 1'b0;
                    if (req != 16'h0000) begin
                        r_grant_idx <= w_winner;
                        r_grant     <= 16'h0001 << w_winner;
                        r_busy      <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (done || !w_owner_req) begin
                        // Normal or abandoned release; done beats the hold limit.
                        r_grant    <= 16'h0000;
                        r_busy     <= 1'b0;
                        r_ptr      <= r_grant_idx + 4'd1;
                        r_hold_cnt <= '0;
                        r_timeout  <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        // Owner used its full allowance; revoke and flag it.
                        r_grant    <= 16'h0000;
                        r_busy     <= 1'b0;
                        r_ptr      <= r_grant_idx + 4'd1;
                        r_hold_cnt <= '0;
                        r_timeout  <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                        r_timeout  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_grant_idx;
    assign busy      = r_busy;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Testbench for rr_arbiter16: directed scenarios plus random traffic, with a
// cycle-level reference model feeding an expected-output queue that a separate
// monitor drains and compares after every clock edge.
module tb_rr_arbiter16;

    localparam int MAX_HOLD = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        busy;
    logic        timeout;

    rr_arbiter16 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] grant;
        logic [3:0]  idx;
        logic        busy;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: who owns the resource, for how many cycles, and where
    // the search starts next time.
    bit m_busy  = 0;
    int m_owner = 0;
    int m_start = 0;
    int m_held  = 0;
    bit m_to    = 0;

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input logic [15:0] r, input logic d, input logic rn);
        if (!rn) begin
            m_busy = 0; m_owner = 0; m_start = 0; m_held = 0; m_to = 0;
        end else if (!m_busy) begin
            m_to = 0;
            for (int k = 0; k < 16; k++) begin
                int c;
                c = (m_start + k) % 16;
                if (r[c]) begin
                    m_busy = 1; m_owner = c; m_held = 1;
                    break;
                end
            end
        end else begin
            m_to = 0;
            if (d || !r[m_owner]) begin
                m_busy = 0; m_start = (m_owner + 1) % 16;
            end else if (m_held == MAX_HOLD) begin
                m_busy = 0; m_start = (m_owner + 1) % 16; m_to = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    // Drive one cycle of stimulus and queue the response expected after the edge.
    task automatic step(input logic [15:0] r, input logic d, input logic rn);
        exp_t e;
        @(negedge clk);
        rst_n = rn;
        req   = r;
        done  = d;
        model_step(r, d, rn);
        e.grant   = m_busy ? (16'h0001 << m_owner) : 16'h0000;
        e.idx     = 4'(m_owner);
        e.busy    = m_busy;
        e.timeout = m_to;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs just after each edge against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant",     int'(grant),     int'(e.grant));
                check("grant_idx", int'(grant_idx), int'(e.idx));
                check("busy",      int'(busy),      int'(e.busy));
                check("timeout",   int'(timeout),   int'(e.timeout));
            end
        end
    end

    initial begin
        logic [15:0] r;
        logic        d;
        rst_n = 1'b0;
        req   = 16'h0000;
        done  = 1'b0;

        // Reset, then a single requester 5 granted and released by done.
        repeat (2) step(16'h0000, 1'b0, 1'b0);
        step(16'h0020, 1'b0, 1'b1);
        step(16'h0020, 1'b0, 1'b1);
        step(16'h0020, 1'b1, 1'b1);
        step(16'h0000, 1'b0, 1'b1);

        // Fairness: everybody requests, each owner finishes after 2 cycles.
        for (int c = 0; c < 52; c++) begin
            d = (m_busy && m_held == 2);
            step(16'hFFFF, d, 1'b1);
        end
        step(16'h0000, 1'b0, 1'b1);

        // Wrap and skip: owner 13 releases, then requesters 0 and 3.
        step(16'h2000, 1'b0, 1'b1);
        step(16'h2000, 1'b1, 1'b1);
        for (int c = 0; c < 8; c++) begin
            d = (m_busy && m_held == 1);
            step(16'h0009, d, 1'b1);
        end

        // Hold limit: requester 8 never signals done.
        step(16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 14; c++) step(16'h0100, 1'b0, 1'b1);

        // done coincides with the hold limit, then an abandoned grant.
        step(16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            d = (m_busy && m_held == MAX_HOLD);
            step(16'h0002, d, 1'b1);
        end
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0040, 1'b0, 1'b1);
        step(16'h0040, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b1);
        step(16'h0000, 1'b0, 1'b1);

        // Asynchronous reset while requester 10 owns the resource.
        step(16'h0400, 1'b0, 1'b1);
        step(16'h0400, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        check("pre_reset_grant", int'(grant), 32'h0400);
        rst_n = 1'b0;
        #1;
        check("async_grant",   int'(grant),   0);
        check("async_busy",    int'(busy),    0);
        check("async_timeout", int'(timeout), 0);
        step(16'h0401, 1'b0, 1'b0);
        step(16'h0401, 1'b0, 1'b1);
        step(16'h0401, 1'b1, 1'b1);
        step(16'h0000, 1'b0, 1'b1);

        // Random traffic: requests change occasionally so hold limits occur.
        r = 16'h0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0: r = 16'($urandom);
                    1: r = 16'h0001 << $urandom_range(0, 15);
                    default: r = 16'($urandom) & 16'($urandom);
                endcase
            end
            d = ($urandom_range(0, 4) == 0);
            step(r, d, ($urandom_range(0, 499) != 0));
        end
        step(16'h0000, 1'b0, 1'b1);

        // Let the monitor drain the queue, with a bounded wait.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rr_arbiter16.md
# rr_arbiter16

Round-robin arbiter sharing one resource among 16 requesters. Samples a 16-bit request vector, picks one winner starting from a rotating priority pointer, and drives the winner as a registered 4-bit index plus a one-hot grant. The grant is held until the owner signals completion, drops its request, or exceeds a hold limit. It sits between the requesting units and the shared resource; the one-hot grant directly enables the winner's datapath.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant; legal range 2..256.
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  16  request vector; bit i high means requester i wants the resource.
- done  input  1  current owner has finished; only meaningful while busy=1.
- grant  output  16  one-hot grant, bit grant_idx set while busy; all-zero otherwise.
- grant_idx  output  4  encoded index of the current owner; holds the last owner when idle.
- busy  output  1  a grant is active.
- timeout  output  1  single-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Internal state: FSM {IDLE, BUSY}; priority pointer ptr[3:0]; hold counter hold_cnt of width clog2(MAX_HOLD).
- Reset values: state=IDLE, ptr=0, hold_cnt=0, grant=16'h0000, grant_idx=0, busy=0, timeout=0.
- IDLE with req==0: remain in IDLE; outputs unchanged.
- IDLE with req!=0: winner = first set bit of req scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
  - Next edge: grant_idx<=winner, grant<=1<<winner, busy<=1, hold_cnt<=0, state<=BUSY.
- BUSY release conditions, in priority order:
  - done=1: normal release.
  - req[grant_idx]=0: abandoned, released like done.
  - hold_cnt==MAX_HOLD-1: forced release; timeout<=1 for one cycle.
- On any release: grant<=0, busy<=0, ptr<=grant_idx+1 (15 wraps to 0), state<=IDLE, hold_cnt<=0.
- BUSY with no release condition: hold_cnt<=hold_cnt+1; grant and grant_idx stable.
- done and the hold limit in the same cycle: done wins and timeout stays 0.
- done while IDLE: ignored.
- Requests from non-owners while BUSY: ignored, with no queuing. Requests are re-evaluated in the next IDLE cycle.
- ptr changes only on release, so the most recent owner has lowest priority next round.
- timeout is 0 in every cycle except the one following a forced release edge.

## Timing
- Arbitration latency: a request seen at edge N (state IDLE) produces grant/busy after edge N.
- Release latency: done seen at edge M produces grant=0 and busy=0 after edge M.
- At least one IDLE cycle always separates consecutive grants. Back-to-back ownership costs 1 bubble cycle.
- Maximum ownership: exactly MAX_HOLD cycles with busy=1. The edge ending cycle MAX_HOLD clears busy and raises timeout.
- All outputs are registered with no combinational path from any input to any output.
- Asynchronous reset mid-grant: outputs clear immediately on rst_n falling, independent of clk. The first arbitration after reset release starts from ptr=0.

## Test plan
- Reset/single requester: hold rst_n=0, then release and set req=16'h0020. After 1 edge: grant=16'h0020, grant_idx=5, busy=1. Assert done for 1 cycle: grant=0 and busy=0 after that edge.
- Round-robin fairness: req=16'hFFFF held constant, with owners pulsing done after 2 busy cycles. Grant order is 0,1,2,…,15,0. Each grant is separated by exactly 1 idle cycle.
- Wrap and skip: with ptr=14 (after owner 13 releases), req=16'h0009. Winner is 0; after release, ptr=1 and the next winner is 3.
- Hold limit: MAX_HOLD=4, req=16'h0100 held, done never asserted. busy=1 for exactly 4 cycles, then grant=0. timeout=1 for 1 cycle. The re-grant to 8 follows after 1 idle cycle.
- Simultaneous events: assert done in the cycle where hold_cnt==MAX_HOLD-1. Release occurs with timeout=0. Separately, drop req[grant_idx] mid-grant: release occurs next edge with timeout=0.
- Reset mid-operation: while grant=16'h0400, drive rst_n low between clock edges. grant, busy and timeout go 0 without a clock edge. After rst_n rises with req=16'h0401, winner is 0.
